// File: rtl/wb_mem_pkg.sv
// Shared definitions for the Wishbone word-memory port.
// Contents:
//   state_e        - 2-bit FSM encoding (IDLE=0, REQ=1, WAIT=2, ACK=3)
//   DEF_BASE_ADDR  - default address window base
//   DEF_ADDR_MASK  - default address window mask (64 B = 16 words)
//   DEF_MISS_DATA  - default read data returned for out-of-window reads
//   sat_inc8       - 8-bit increment that sticks at 8'hFF
package wb_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_ACK  = 2'd3
    } state_e;

    localparam logic [31:0] DEF_BASE_ADDR = 32'h3000_0000;
    localparam logic [31:0] DEF_ADDR_MASK = 32'hFFFF_FFC0;
    localparam logic [31:0] DEF_MISS_DATA = 32'h0000_0000;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/wb_addr_match.sv
// Combinational address-window decoder.
// Ports:
//   adr_i  in  32  byte address
//   hit_o  out 1   address falls inside the window (adr & ADDR_MASK) == BASE_ADDR
module wb_addr_match #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter logic [31:0] ADDR_MASK = 32'hFFFF_FFC0
) (
    input  logic [31:0] adr_i,
    output logic        hit_o
);

    assign hit_o = ((adr_i & ADDR_MASK) == BASE_ADDR);

endmodule

// File: rtl/wb_mem_port.sv
// Wishbone classic slave front end for the user-project word memory.
// Decodes an address window, issues one single-cycle request per transfer
// to the memory backend, waits the fixed backend read latency and returns
// one ack per transfer. At most one transfer is outstanding.
// Ports:
//   wb_clk_i, wb_rst_i          clock, asynchronous active-high reset
//   wbs_cyc_i/stb_i/we_i        Wishbone cycle, strobe, write enable
//   wbs_sel_i[3:0]              byte selects
//   wbs_adr_i[31:0]             byte address
//   wbs_dat_i[31:0]             write data
//   wbs_ack_o                   one-cycle ack per transfer
//   wbs_dat_o[31:0]             registered read data
//   mem_req                     backend request strobe (one cycle)
//   mem_we, mem_addr[AW-1:0]    backend write flag and word index
//   mem_be[3:0], mem_wdata      backend byte enables and write data
//   mem_rdata[31:0]             backend read data, valid READ_LAT cycles after mem_req
//   busy                        FSM not idle
//   miss_count[7:0]             saturating count of out-of-window accesses
module wb_mem_port
    import wb_mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
    parameter logic [31:0] ADDR_MASK = DEF_ADDR_MASK,
    parameter int unsigned AW        = 4,
    parameter int unsigned READ_LAT  = 1,
    parameter logic [31:0] MISS_DATA = DEF_MISS_DATA
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          wbs_cyc_i,
    input  logic          wbs_stb_i,
    input  logic          wbs_we_i,
    input  logic [3:0]    wbs_sel_i,
    input  logic [31:0]   wbs_adr_i,
    input  logic [31:0]   wbs_dat_i,
    output logic          wbs_ack_o,
    output logic [31:0]   wbs_dat_o,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [3:0]    mem_be,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    output logic          busy,
    output logic [7:0]    miss_count
);

    localparam int unsigned   CW       = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [CW-1:0] LAT_LOAD = CW'(READ_LAT - 1);

    state_e          state_q;
    logic            ack_q;
    logic [31:0]     rdat_q;
    logic            req_q;
    logic            we_q;
    logic [AW-1:0]   addr_q;
    logic [3:0]      be_q;
    logic [31:0]     wdata_q;
    logic [CW-1:0]   cnt_q;
    logic [7:0]      miss_q;
    logic            hit;

    wb_addr_match #(
        .BASE_ADDR (BASE_ADDR),
        .ADDR_MASK (ADDR_MASK)
    ) u_match (
        .adr_i (wbs_adr_i),
        .hit_o (hit)
    );

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
            rdat_q  <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            miss_q  <= '0;
        end else begin
            // Strobes default low so each is a single-cycle pulse.
            req_q <= 1'b0;
            ack_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (wbs_cyc_i && wbs_stb_i) begin
                        we_q    <= wbs_we_i;
                        be_q    <= wbs_sel_i;
                        addr_q  <= wbs_adr_i[AW+1:2];
                        wdata_q <= wbs_dat_i;
                        if (!hit) begin
                            // Misses never reach the backend; writes are dropped.
                            state_q <= ST_ACK;
                            ack_q   <= 1'b1;
                            miss_q  <= sat_inc8(miss_q);
                            if (!wbs_we_i) begin
                                rdat_q <= MISS_DATA;
                            end
                        end else begin
                            // A write with no byte enables keeps write-hit timing
                            // but never strobes the backend.
                            state_q <= ST_REQ;
                            req_q   <= !(wbs_we_i && (wbs_sel_i == 4'b0000));
                        end
                    end
                end
                ST_REQ: begin
                    if (!wbs_cyc_i) begin
                        state_q <= ST_IDLE;
                    end else if (we_q) begin
                        state_q <= ST_ACK;
                        ack_q   <= 1'b1;
                    end else begin
                        state_q <= ST_WAIT;
                        cnt_q   <= LAT_LOAD;
                    end
                end
                ST_WAIT: begin
                    if (!wbs_cyc_i) begin
                        state_q <= ST_IDLE;
                    end else if (cnt_q == '0) begin
                        rdat_q  <= mem_rdata;
                        ack_q   <= 1'b1;
                        state_q <= ST_ACK;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                ST_ACK: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Master dropping cyc during the ack cycle aborts the transfer, so the
    // registered ack is qualified with the live cycle signal.
    assign wbs_ack_o  = ack_q & wbs_cyc_i;
    assign wbs_dat_o  = rdat_q;
    assign mem_req    = req_q;
    assign mem_we     = we_q;
    assign mem_addr   = addr_q;
    assign mem_be     = be_q;
    assign mem_wdata  = wdata_q;
    assign busy       = (state_q != ST_IDLE);
    assign miss_count = miss_q;

endmodule

// File: tb/tb_wb_mem_port.sv
module tb_wb_mem_port;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [31:0] MASK = 32'hFFFF_FFC0;
    localparam logic [31:0] MISS = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        tgt;
    logic        m_cyc, m_stb, m_we;
    logic [3:0]  m_sel;
    logic [31:0] m_adr, m_dat;

    logic        a_cyc, a_stb, b_cyc, b_stb;
    logic        a_ack, a_req, a_we, a_busy, b_ack, b_req, b_we, b_busy;
    logic [31:0] a_dat, a_wdata, a_rdata, b_dat, b_wdata, b_rdata;
    logic [3:0]  a_addr, a_be, b_addr, b_be;
    logic [7:0]  a_miss, b_miss;

    logic        o_ack, o_req, o_we, o_busy;
    logic [31:0] o_dat, o_wdata;
    logic [3:0]  o_addr, o_be;
    logic [7:0]  o_miss;

    int ntests = 0;
    int nfail  = 0;

    // Reference model state, per target (0: READ_LAT=1, 1: READ_LAT=3)
    logic [31:0] refm [2][16];
    logic [31:0] last_rd [2];
    int          miss_m [2];

    always #5 clk = ~clk;

    assign a_cyc = m_cyc & ~tgt;
    assign a_stb = m_stb & ~tgt;
    assign b_cyc = m_cyc & tgt;
    assign b_stb = m_stb & tgt;

    assign o_ack   = tgt ? b_ack   : a_ack;
    assign o_req   = tgt ? b_req   : a_req;
    assign o_we    = tgt ? b_we    : a_we;
    assign o_busy  = tgt ? b_busy  : a_busy;
    assign o_dat   = tgt ? b_dat   : a_dat;
    assign o_wdata = tgt ? b_wdata : a_wdata;
    assign o_addr  = tgt ? b_addr  : a_addr;
    assign o_be    = tgt ? b_be    : a_be;
    assign o_miss  = tgt ? b_miss  : a_miss;

    wb_mem_port #(.READ_LAT(1)) dut_a (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_cyc_i(a_cyc), .wbs_stb_i(a_stb), .wbs_we_i(m_we), .wbs_sel_i(m_sel),
        .wbs_adr_i(m_adr), .wbs_dat_i(m_dat), .wbs_ack_o(a_ack), .wbs_dat_o(a_dat),
        .mem_req(a_req), .mem_we(a_we), .mem_addr(a_addr), .mem_be(a_be),
        .mem_wdata(a_wdata), .mem_rdata(a_rdata), .busy(a_busy), .miss_count(a_miss)
    );

    wb_mem_port #(.READ_LAT(3)) dut_b (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_cyc_i(b_cyc), .wbs_stb_i(b_stb), .wbs_we_i(m_we), .wbs_sel_i(m_sel),
        .wbs_adr_i(m_adr), .wbs_dat_i(m_dat), .wbs_ack_o(b_ack), .wbs_dat_o(b_dat),
        .mem_req(b_req), .mem_we(b_we), .mem_addr(b_addr), .mem_be(b_be),
        .mem_wdata(b_wdata), .mem_rdata(b_rdata), .busy(b_busy), .miss_count(b_miss)
    );

    // Behavioural backends: byte-enabled word memories whose read data is
    // only valid READ_LAT cycles after the request; otherwise junk.
    logic [31:0] bmem_a [16];
    logic [31:0] bmem_b [16];
    logic [31:0] junk;
    logic        av;
    logic [31:0] ad;
    logic [2:0]  bv;
    logic [31:0] bd [3];

    always @(posedge clk) begin
        junk  <= $urandom;
        av    <= a_req & ~a_we;
        ad    <= bmem_a[a_addr];
        bv    <= {bv[1:0], b_req & ~b_we};
        bd[0] <= bmem_b[b_addr];
        bd[1] <= bd[0];
        bd[2] <= bd[1];
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                bmem_a[i] <= '0;
                bmem_b[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (a_req && a_we && a_be[i]) bmem_a[a_addr][i*8 +: 8] <= a_wdata[i*8 +: 8];
                if (b_req && b_we && b_be[i]) bmem_b[b_addr][i*8 +: 8] <= b_wdata[i*8 +: 8];
            end
        end
    end

    assign a_rdata = av    ? ad    : junk;
    assign b_rdata = bv[2] ? bd[2] : ~junk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int t = 0; t < 2; t++) begin
            last_rd[t] = '0;
            miss_m[t]  = 0;
            for (int i = 0; i < 16; i++) refm[t][i] = '0;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ack"},   {31'd0, o_ack},  32'd0);
        chk({tag, "_dat"},   o_dat,           32'd0);
        chk({tag, "_req"},   {31'd0, o_req},  32'd0);
        chk({tag, "_we"},    {31'd0, o_we},   32'd0);
        chk({tag, "_addr"},  {28'd0, o_addr}, 32'd0);
        chk({tag, "_be"},    {28'd0, o_be},   32'd0);
        chk({tag, "_wdata"}, o_wdata,         32'd0);
        chk({tag, "_busy"},  {31'd0, o_busy}, 32'd0);
        chk({tag, "_miss"},  {24'd0, o_miss}, 32'd0);
    endtask

    function automatic logic [31:0] rand_miss_adr();
        logic [31:0] a;
        a = $urandom;
        if ((a & MASK) == BASE) a = a ^ 32'h0000_0100;
        return a;
    endfunction

    // One complete transfer. Called at a negedge; drives immediately so the
    // following posedge is the sampling edge (edge 0). Returns at the negedge
    // of the idle cycle that follows the ack.
    task automatic xfer(input logic t, input logic [31:0] adr, input logic we,
                        input logic [3:0] sel, input logic [31:0] dat, input logic keep);
        logic        hit, got, exp_req;
        logic [3:0]  idx;
        logic [31:0] exp_dat, cap_addr, cap_be, cap_wdata, cap_we;
        int          lat_exp, k, nreq;
        hit     = ((adr & MASK) == BASE);
        idx     = adr[5:2];
        lat_exp = !hit ? 1 : (we ? 2 : 2 + (t ? 3 : 1));
        exp_req = hit && !(we && sel == 4'b0000);
        tgt = t; m_cyc = 1'b1; m_stb = 1'b1; m_we = we; m_sel = sel; m_adr = adr; m_dat = dat;
        k = 0; nreq = 0; got = 1'b0;
        cap_addr = '0; cap_be = '0; cap_wdata = '0; cap_we = '0;
        while (!got && k < 20) begin
            @(negedge clk);
            k++;
            if (o_req) begin
                nreq++;
                cap_we = {31'd0, o_we}; cap_addr = {28'd0, o_addr};
                cap_be = {28'd0, o_be}; cap_wdata = o_wdata;
            end
            if (o_ack) got = 1'b1;
        end
        chk("ack_latency", got ? k : 999, lat_exp);
        chk("req_count", nreq, exp_req ? 1 : 0);
        if (exp_req) begin
            chk("req_we",   cap_we,   {31'd0, we});
            chk("req_addr", cap_addr, {28'd0, idx});
            chk("req_be",   cap_be,   {28'd0, sel});
            if (we) chk("req_wdata", cap_wdata, dat);
            chk("addr_held", {28'd0, o_addr}, {28'd0, idx});
        end
        if (!hit) begin
            miss_m[t] = (miss_m[t] >= 255) ? 255 : miss_m[t] + 1;
            if (!we) last_rd[t] = MISS;
        end else if (we) begin
            for (int i = 0; i < 4; i++)
                if (sel[i]) refm[t][idx][i*8 +: 8] = dat[i*8 +: 8];
        end else begin
            last_rd[t] = refm[t][idx];
        end
        exp_dat = last_rd[t];
        chk("rd_data", o_dat, exp_dat);
        chk("miss_count", {24'd0, o_miss}, miss_m[t]);
        chk("busy_in_ack", {31'd0, o_busy}, 32'd1);
        if (!keep) begin
            m_cyc = 1'b0; m_stb = 1'b0;
        end
        @(negedge clk);
        chk("idle_after", {30'd0, o_busy, o_ack}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; tgt = 1'b0;
        m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0; m_sel = '0; m_adr = '0; m_dat = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk_all_zero("rst_a");
        tgt = 1'b1;
        #1 chk_all_zero("rst_b");
        tgt = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed: write hit, read it back, miss, zero-select write
        xfer(1'b0, 32'h3000_0008, 1'b1, 4'hF, 32'hA5A5_1234, 1'b0);
        xfer(1'b0, 32'h3000_0008, 1'b0, 4'hF, 32'h0,         1'b0);
        chk("dir_read_val", o_dat, 32'hA5A5_1234);
        xfer(1'b0, 32'h3000_0100, 1'b0, 4'hF, 32'h0,         1'b0);
        chk("dir_miss_cnt", {24'd0, o_miss}, 32'd1);
        xfer(1'b0, 32'h3000_000C, 1'b1, 4'h0, 32'hDEAD_BEEF, 1'b0);
        xfer(1'b0, 32'h3000_000C, 1'b0, 4'hF, 32'h0,         1'b0);

        // Abort: drop cyc while waiting for read data
        m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b0; m_sel = 4'hF; m_adr = 32'h3000_0010;
        @(negedge clk);
        chk("abort_req", {31'd0, o_req}, 32'd1);
        @(negedge clk);
        chk("abort_wait_ack", {31'd0, o_ack}, 32'd0);
        m_cyc = 1'b0; m_stb = 1'b0;
        @(negedge clk);
        chk("abort_ack", {31'd0, o_ack}, 32'd0);
        chk("abort_busy", {31'd0, o_busy}, 32'd0);
        chk("abort_dat", o_dat, last_rd[0]);
        @(negedge clk);
        chk("abort_still_idle", {30'd0, o_busy, o_ack}, 32'd0);

        // Asynchronous reset while the request is on the bus
        xfer(1'b0, 32'h3000_0008, 1'b0, 4'hF, 32'h0, 1'b0);
        m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b1; m_sel = 4'hF;
        m_adr = 32'h3000_0014; m_dat = 32'h1234_5678;
        @(negedge clk);
        chk("rstreq_req", {31'd0, o_req}, 32'd1);
        chk("rstreq_busy", {31'd0, o_busy}, 32'd1);
        #1 rst = 1'b1;
        #1 chk_all_zero("rst_mid");
        m_cyc = 1'b0; m_stb = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        xfer(1'b0, 32'h3000_0014, 1'b0, 4'hF, 32'h0, 1'b0);

        // Randomized mix on the READ_LAT=1 port
        for (int i = 0; i < 150; i++) begin
            logic [31:0] adr;
            logic [3:0]  sel;
            if ($urandom_range(3) != 0) adr = BASE | ($urandom_range(15) << 2) | $urandom_range(3);
            else                        adr = rand_miss_adr();
            sel = ($urandom_range(4) == 0) ? 4'h0 : 4'($urandom);
            xfer(1'b0, adr, 1'($urandom), sel, $urandom, 1'($urandom));
        end

        // Saturation of the miss counter
        for (int i = 0; i < 256; i++) begin
            xfer(1'b0, rand_miss_adr(), 1'($urandom), 4'hF, $urandom, 1'b0);
        end
        chk("miss_saturated", {24'd0, o_miss}, 32'h0000_00FF);

        // READ_LAT=3 port: fill some words, then back-to-back reads
        for (int i = 0; i < 16; i++) begin
            xfer(1'b1, BASE | (i << 2), 1'b1, 4'($urandom), $urandom, 1'b1);
        end
        for (int i = 0; i < 24; i++) begin
            xfer(1'b1, BASE | ($urandom_range(15) << 2), 1'b0, 4'hF, 32'h0, (i != 23));
        end
        xfer(1'b1, 32'h3000_0040, 1'b0, 4'hF, 32'h0, 1'b0);
        chk("b_miss_count", {24'd0, o_miss}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
